// File: rtl/uart_cmd_echo_ctrl.sv
// Command/echo controller between a UART byte receiver and transmitter.
// Received bytes update output flags, and echoes/status replies are queued in a FIFO that feeds the TX handshake.
module uart_cmd_echo_ctrl #(
    parameter int          N_FLAGS      = 4,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [3:0]  SET_NIB      = 4'hF,
    parameter logic [3:0]  CLR_NIB      = 4'hA,
    parameter logic [3:0]  TOG_NIB      = 4'h5,
    parameter logic [7:0]  QUERY_BYTE   = 8'h3F,
    parameter logic [7:0]  OVF_CLR_BYTE = 8'hE0
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic                          echo_en,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_done,
    input  logic                          tx_done,
    output logic [7:0]                    tx_data,
    output logic                          send_go,
    output logic [N_FLAGS-1:0]            flags,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [7:0]         r_tx_data;
    logic               r_send_go;
    logic [N_FLAGS-1:0] r_flags;
    logic               r_overflow;
    logic [LVL_W-1:0]   r_level;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [7:0]         r_mem [FIFO_DEPTH];

    logic [N_FLAGS-1:0] w_flags_nxt;
    logic [7:0]         w_flags_byte;
    logic [7:0]         w_push_data;
    logic               w_push;
    logic               w_ovf_clr;
    logic               w_full;
    logic               w_pop;
    logic               w_acc;
    logic               w_drop;

    // Byte decode: flag update, push request and overflow-clear request
    always_comb begin
        w_flags_nxt  = r_flags;
        w_flags_byte = 8'h00;
        w_flags_byte[N_FLAGS-1:0] = r_flags;
        w_push       = 1'b0;
        w_push_data  = 8'h00;
        w_ovf_clr    = 1'b0;
        if (rx_done) begin
            if (rx_data == QUERY_BYTE) begin
                // status reply reflects the flags before this byte
                w_push      = 1'b1;
                w_push_data = w_flags_byte;
            end else begin
                w_push      = echo_en;
                w_push_data = rx_data;
                w_ovf_clr   = (rx_data == OVF_CLR_BYTE);
                // indices at or above N_FLAGS never match and are ignored
                for (int i = 0; i < N_FLAGS; i++) begin
                    if (rx_data[3:0] == 4'(i)) begin
                        case (rx_data[7:4])
                            SET_NIB: w_flags_nxt[i] = 1'b1;
                            CLR_NIB: w_flags_nxt[i] = 1'b0;
                            TOG_NIB: w_flags_nxt[i] = ~r_flags[i];
                            default: w_flags_nxt[i] = r_flags[i];
                        endcase
                    end else begin
                        w_flags_nxt[i] = r_flags[i];
                    end
                end
            end
        end else begin
            w_flags_nxt = r_flags;
        end
    end

    // FIFO control: a full FIFO still accepts a push when the same edge pops
    always_comb begin
        w_full = (r_level == LVL_FULL);
        w_pop  = (r_state == ST_IDLE) && (r_level != LVL_ZERO);
        w_acc  = w_push && (!w_full || w_pop);
        w_drop = w_push && w_full && !w_pop;
    end

    // Flag and sticky overflow registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_flags    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_flags <= w_flags_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= LVL_ZERO;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_acc) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_acc, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // TX handshake FSM: one byte in flight, send_go held until tx_done
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= ST_IDLE;
            r_tx_data <= 8'h00;
            r_send_go <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= r_mem[r_rd_ptr];
                        r_send_go <= 1'b1;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (tx_done) begin
                        r_send_go <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_send_go <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data    = r_tx_data;
    assign send_go    = r_send_go;
    assign flags      = r_flags;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_cmd_echo_ctrl.sv
// Directed bench for uart_cmd_echo_ctrl; expected TX bytes go into a scoreboard
// queue and a separate monitor checks each byte when send_go rises.
module tb_uart_cmd_echo_ctrl;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       echo_en;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       send_go;
    logic [3:0] flags;
    logic [3:0] fifo_level;
    logic       overflow;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];

    uart_cmd_echo_ctrl dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .echo_en    (echo_en),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .tx_done    (tx_done),
        .tx_data    (tx_data),
        .send_go    (send_go),
        .flags      (flags),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic echoed);
        if (echoed) exp_q.push_back(b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((send_go || fifo_level != 4'd0) && guard < 300) begin
            if (send_go) begin
                step();
                step();
                done_pulse();
            end else begin
                step();
            end
            guard++;
        end
        check("drain_timeout", (guard >= 300) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // Scoreboard monitor: each rising send_go must present the next expected byte
    initial begin
        logic       prev_go;
        logic [7:0] e;
        prev_go = 1'b0;
        forever begin
            @(negedge clk);
            if (send_go && !prev_go) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_tx: got %h expected no transmission", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {24'd0, tx_data}, {24'd0, e});
                end
            end
            prev_go = send_go;
        end
    end

    initial begin
        n_reset = 1'b0;
        echo_en = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flags",    {28'd0, flags},      32'd0);
        check("rst_send_go",  {31'd0, send_go},    32'd0);
        check("rst_level",    {28'd0, fifo_level}, 32'd0);
        check("rst_overflow", {31'd0, overflow},   32'd0);
        check("rst_tx_data",  {24'd0, tx_data},    32'd0);
        n_reset = 1'b1;
        step();

        // T1: set flag 1, echo, latency
        echo_en = 1'b1;
        rx_send(8'hF1, 1'b1);
        check("t1_flags",     {28'd0, flags},      32'h2);
        check("t1_go_e0",     {31'd0, send_go},    32'd0);
        check("t1_level_e0",  {28'd0, fifo_level}, 32'd1);
        step();
        check("t1_go_e1",     {31'd0, send_go},    32'd1);
        check("t1_tx_data",   {24'd0, tx_data},    32'hF1);
        step();
        done_pulse();
        check("t1_go_done",   {31'd0, send_go},    32'd0);
        check("t1_level_end", {28'd0, fifo_level}, 32'd0);

        // T2: toggle/clear/out-of-range, back-to-back gap
        rx_send(8'h52, 1'b1);
        rx_send(8'h51, 1'b1);
        rx_send(8'hA3, 1'b1);
        rx_send(8'hF9, 1'b1);
        check("t2_flags", {28'd0, flags}, 32'h4);
        done_pulse();
        check("t2_gap_low",  {31'd0, send_go}, 32'd0);
        step();
        check("t2_gap_high", {31'd0, send_go}, 32'd1);
        drain();

        // T3: echo off, status query, silent byte
        echo_en = 1'b0;
        rx_send(8'hF1, 1'b0);
        rx_send(8'h52, 1'b0);
        rx_send(8'hF3, 1'b0);
        check("t3_flags", {28'd0, flags}, 32'hA);
        exp_q.push_back(8'h0A);
        rx_send(8'h3F, 1'b0);
        drain();
        rx_send(8'h77, 1'b0);
        repeat (5) step();
        check("t3_quiet_go",    {31'd0, send_go},    32'd0);
        check("t3_quiet_level", {28'd0, fifo_level}, 32'd0);

        // T4: overflow with tx_done withheld, then clear on a pop edge
        echo_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rx_send(8'h10 + 8'(i), (i < 9));
        end
        check("t4_level",    {28'd0, fifo_level}, 32'd8);
        check("t4_overflow", {31'd0, overflow},   32'd1);
        check("t4_tx_data",  {24'd0, tx_data},    32'h10);
        done_pulse();
        rx_send(8'hE0, 1'b1);
        check("t4_ovf_clr",     {31'd0, overflow},   32'd0);
        check("t4_level_after", {28'd0, fifo_level}, 32'd8);
        check("t4_next_tx",     {24'd0, tx_data},    32'h11);

        // T5: push into full FIFO on a pop edge is accepted
        done_pulse();
        rx_send(8'h20, 1'b1);
        check("t5_overflow", {31'd0, overflow},   32'd0);
        check("t5_level",    {28'd0, fifo_level}, 32'd8);
        drain();

        // T6: asynchronous reset mid-transfer, stray tx_done afterwards
        rx_send(8'h30, 1'b1);
        rx_send(8'h31, 1'b1);
        rx_send(8'h32, 1'b1);
        rx_send(8'h33, 1'b1);
        check("t6_pre_level", {28'd0, fifo_level}, 32'd3);
        check("t6_pre_go",    {31'd0, send_go},    32'd1);
        #3;
        n_reset = 1'b0;
        #1;
        check("t6_rst_go",    {31'd0, send_go},    32'd0);
        check("t6_rst_flags", {28'd0, flags},      32'd0);
        check("t6_rst_level", {28'd0, fifo_level}, 32'd0);
        check("t6_rst_txd",   {24'd0, tx_data},    32'd0);
        exp_q.delete();
        step();
        n_reset = 1'b1;
        step();
        done_pulse();
        repeat (3) step();
        check("t6_stray_go",    {31'd0, send_go},    32'd0);
        check("t6_stray_level", {28'd0, fifo_level}, 32'd0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
